// File: rtl/multdiv_pkg.sv
// Shared constants and helpers for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int unsigned ITERS   = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Magnitude of a two's complement value; INT_MIN maps to 2^31 as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/multdiv_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module multdiv_div_step (
    input  logic [31:0] rem,
    input  logic        dividend_bit,
    input  logic [31:0] divisor,
    output logic [31:0] next_rem,
    output logic        quo_bit
);

    logic [32:0] shifted;
    logic [33:0] diff;

    always_comb begin
        shifted  = {rem, dividend_bit};
        diff     = {1'b0, shifted} - {2'b00, divisor};
        quo_bit  = ~diff[33];
        // rem < divisor on entry, so a successful subtraction fits in 32 bits.
        next_rem = quo_bit ? diff[31:0] : shifted[31:0];
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide unit: shift-add multiply, restoring divide.
module multdiv_unit #(
    parameter int unsigned ITERS = multdiv_pkg::ITERS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] result,
    output logic        exception,
    output logic        resultRDY,
    output logic        busy
);
    import multdiv_pkg::*;

    logic [1:0]  state_q;
    logic [5:0]  cnt_q;
    logic        op_div_q;
    logic        neg_q;
    // Multiply: opa = shifted multiplicand, opb = multiplier, acc = product.
    // Divide:   opa = divisor, opb = dividend shifting out / quotient shifting in, acc = remainder.
    logic [63:0] opa_q;
    logic [31:0] opb_q;
    logic [63:0] acc_q;
    logic [31:0] result_q;
    logic        exc_q;

    logic        accept;
    logic        start_div;
    logic        last_iter;
    logic [31:0] div_rem;
    logic        div_qbit;
    logic [63:0] acc_step;
    logic [63:0] opa_step;
    logic [31:0] opb_step;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] fin_result;
    logic        fin_exc;

    assign accept    = (ctrl_MULT | ctrl_DIV) && (state_q != StRun);
    assign start_div = ctrl_DIV && !ctrl_MULT;
    assign last_iter = (state_q == StRun) && (cnt_q == 6'(ITERS - 1));

    multdiv_div_step u_div_step (
        .rem          (acc_q[31:0]),
        .dividend_bit (opb_q[31]),
        .divisor      (opa_q[31:0]),
        .next_rem     (div_rem),
        .quo_bit      (div_qbit)
    );

    always_comb begin
        if (op_div_q) begin
            acc_step = {32'd0, div_rem};
            opa_step = opa_q;
            opb_step = {opb_q[30:0], div_qbit};
        end else begin
            acc_step = acc_q + (opb_q[0] ? opa_q : 64'd0);
            opa_step = {opa_q[62:0], 1'b0};
            opb_step = {1'b0, opb_q[31:1]};
        end
        prod       = neg_q ? (64'd0 - acc_step) : acc_step;
        quo        = neg_q ? (32'd0 - opb_step) : opb_step;
        fin_result = op_div_q ? quo : prod[31:0];
        // A positive quotient of 2^31 only arises from INT_MIN / -1.
        fin_exc    = op_div_q ? (!neg_q && (opb_step == INT_MIN))
                              : !((&prod[63:31]) || !(|prod[63:31]));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= 6'd0;
            op_div_q <= 1'b0;
            neg_q    <= 1'b0;
            opa_q    <= 64'd0;
            opb_q    <= 32'd0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
        end else if (accept) begin
            cnt_q    <= 6'd0;
            op_div_q <= start_div;
            neg_q    <= operandA[31] ^ operandB[31];
            acc_q    <= 64'd0;
            opa_q    <= {32'd0, start_div ? mag32(operandB) : mag32(operandA)};
            opb_q    <= start_div ? mag32(operandA) : mag32(operandB);
            if (start_div && (operandB == 32'd0)) begin
                state_q  <= StDone;
                result_q <= 32'd0;
                exc_q    <= 1'b1;
            end else begin
                state_q  <= StRun;
                exc_q    <= 1'b0;
            end
        end else if (state_q == StRun) begin
            acc_q <= acc_step;
            opa_q <= opa_step;
            opb_q <= opb_step;
            cnt_q <= cnt_q + 6'd1;
            if (last_iter) begin
                state_q  <= StDone;
                result_q <= fin_result;
                exc_q    <= fin_exc;
            end
        end else if (state_q == StDone) begin
            state_q <= StIdle;
        end
    end

    assign result    = result_q;
    assign exception = exc_q;
    assign resultRDY = (state_q == StDone);
    assign busy      = (state_q == StRun);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed and randomised scoreboard bench for multdiv_unit.
module tb_multdiv_unit;
    import multdiv_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] result;
    logic        exception;
    logic        resultRDY;
    logic        busy;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    multdiv_unit #(.ITERS(ITERS)) dut (
        .clock     (clock),
        .reset     (reset),
        .operandA  (operandA),
        .operandB  (operandB),
        .ctrl_MULT (ctrl_MULT),
        .ctrl_DIV  (ctrl_DIV),
        .result    (result),
        .exception (exception),
        .resultRDY (resultRDY),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic mul, input logic [31:0] a, input logic [31:0] b);
        exp_t             e;
        logic signed [63:0] sa;
        logic signed [63:0] sb64;
        logic signed [63:0] p;
        e.lat = 32;
        e.exc = 1'b0;
        if (mul) begin
            sa    = {{32{a[31]}}, a};
            sb64  = {{32{b[31]}}, b};
            p     = sa * sb64;
            e.res = p[31:0];
            e.exc = !((&p[63:31]) || !(|p[63:31]));
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
            e.lat = 0;
        end else if (a == INT_MIN && b == 32'hFFFF_FFFF) begin
            e.res = INT_MIN;
            e.exc = 1'b1;
        end else begin
            e.res = $signed(a) / $signed(b);
        end
        return e;
    endfunction

    // Drive a start pulse for one edge (E0); returns at E0+1 with operands scrambled.
    task automatic issue(input logic mul, input logic div, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ee,
                         input int lat);
        exp_t e;
        @(negedge clock);
        operandA  = a;
        operandB  = b;
        ctrl_MULT = mul;
        ctrl_DIV  = div;
        e.res = er;
        e.exc = ee;
        e.lat = lat;
        sb.push_back(e);
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        operandA  = $urandom;
        operandB  = $urandom;
    endtask

    task automatic wait_done(input string tag, input int c0);
        exp_t e;
        int   c;
        logic early;
        if (sb.size() == 0) begin
            check({tag, " scoreboard underflow"}, 32'd1, 32'd0);
            return;
        end
        e     = sb.pop_front();
        c     = c0;
        early = 1'b0;
        while (resultRDY !== 1'b1 && c < 80) begin
            if (busy !== 1'b1) early = 1'b1;
            @(posedge clock);
            #1;
            c++;
        end
        check({tag, " latency"}, c, e.lat);
        check({tag, " result"}, result, e.res);
        check({tag, " exception"}, {31'd0, exception}, {31'd0, e.exc});
        check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
        check({tag, " busy dropped early"}, {31'd0, early}, 32'd0);
    endtask

    task automatic rdy_low_next(input string tag);
        @(posedge clock);
        #1;
        check({tag, " rdy pulse width"}, {31'd0, resultRDY}, 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic fault;
        logic mul;
        logic [31:0] a;
        logic [31:0] b;
        int bi;

        reset     = 1'b0;
        operandA  = 32'd0;
        operandB  = 32'd0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        #12;
        check("reset result", result, 32'd0);
        check("reset exception", {31'd0, exception}, 32'd0);
        check("reset resultRDY", {31'd0, resultRDY}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        issue(1'b1, 1'b0, 32'd7, -32'sd3, 32'hFFFF_FFEB, 1'b0, 32);
        wait_done("mul 7*-3", 0);
        rdy_low_next("mul 7*-3");

        issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 32);
        wait_done("mul overflow", 0);
        issue(1'b1, 1'b0, -32'sd65536, 32'd32768, INT_MIN, 1'b0, 32);
        wait_done("mul int_min fit", 0);

        issue(1'b0, 1'b1, -32'sd7, 32'd2, 32'hFFFF_FFFD, 1'b0, 32);
        wait_done("div -7/2", 0);
        issue(1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1, 0);
        wait_done("div by zero", 0);
        rdy_low_next("div by zero");
        issue(1'b0, 1'b1, INT_MIN, 32'hFFFF_FFFF, INT_MIN, 1'b1, 32);
        wait_done("div int_min/-1", 0);

        issue(1'b1, 1'b1, 32'd6, 32'd7, 32'd42, 1'b0, 32);
        wait_done("mult wins", 0);

        // DIV pulse at E10 of a running MULT must be dropped.
        issue(1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0, 32);
        repeat (9) @(posedge clock);
        @(negedge clock);
        operandA = 32'd9;
        operandB = 32'd3;
        ctrl_DIV = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        wait_done("start during run", 10);

        // Start accepted in DONE: old pulse ends, busy rises on the same edge.
        issue(1'b0, 1'b1, 32'd9, 32'd3, 32'd3, 1'b0, 32);
        check("done restart rdy", {31'd0, resultRDY}, 32'd0);
        check("done restart busy", {31'd0, busy}, 32'd1);
        wait_done("div 9/3 from done", 0);

        // Asynchronous reset at E15 of a multiply discards the operation.
        issue(1'b1, 1'b0, 32'd1000, 32'd1000, 32'd1_000_000, 1'b0, 32);
        void'(sb.pop_front());
        repeat (15) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async reset result", result, 32'd0);
        check("async reset busy", {31'd0, busy}, 32'd0);
        check("async reset resultRDY", {31'd0, resultRDY}, 32'd0);
        check("async reset exception", {31'd0, exception}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        fault = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (resultRDY !== 1'b0 || busy !== 1'b0) fault = 1'b1;
        end
        check("no activity after reset", {31'd0, fault}, 32'd0);
        issue(1'b1, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0, 32);
        wait_done("mul 2*2 after reset", 0);

        for (int i = 0; i < 6; i++) begin
            mul = i[0];
            a   = $urandom;
            if (mul) begin
                b = $urandom;
            end else begin
                bi = int'($urandom_range(0, 2000)) - 1000;
                b  = bi;
            end
            e = model(mul, a, b);
            issue(mul, !mul, a, b, e.res, e.exc, e.lat);
            wait_done(mul ? "random mul" : "random div", 0);
        end

        check("scoreboard empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
